// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNT   = 3'd1,
    ST_DATA    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Largest word count a frame may carry for a given memory address width.
  function automatic int unsigned max_words(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  // Stream source / memory observer side.
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs byte beats into big-endian 32-bit words and keeps a running XOR.
module imem_loader_byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        beat,
  input  logic [7:0]  beat_data,
  output logic [31:0] word_next,
  output logic        word_complete,
  output logic [7:0]  acc
);
  import imem_loader_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  // Only the three most recent bytes are needed; the fourth arrives with the beat.
  logic [23:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  acc_q, acc_d;

  assign word_next     = {word_q, beat_data};
  assign word_complete = beat && (idx_q == LAST_IDX);
  assign acc           = acc_q;

  // Next-state for shift register, byte index and checksum accumulator.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
      acc_d  = '0;
    end else if (beat) begin
      word_d = word_next[23:0];
      idx_d  = idx_q + 2'd1;
      acc_d  = acc_q ^ beat_data;
    end
  end

  // Packer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a framed byte stream while the CPU is halted,
// then pulses CPU reset when the frame checksum is good.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          halt_cpu,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);
  import imem_loader_pkg::*;

  localparam logic [8:0]          MAX_N    = 9'(max_words(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] ONE_WORD = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  halt_q, halt_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;

  logic        xfer;
  logic        pk_clear;
  logic        pk_beat;
  logic [31:0] pk_word;
  logic        pk_complete;
  logic [7:0]  pk_acc;

  assign xfer = bus.rx_valid && rx_ready_q;

  imem_loader_byte_packer u_packer (
    .clock         (clock),
    .reset         (reset),
    .clear         (pk_clear),
    .beat          (pk_beat),
    .beat_data     (bus.rx_data),
    .word_next     (pk_word),
    .word_complete (pk_complete),
    .acc           (pk_acc)
  );

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign halt_cpu      = halt_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

  // Frame sequencing; rx_ready/busy/cpu_reset are decoded from the next state
  // so that they are registered yet line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    halt_d       = halt_q;
    done_d       = done_q;
    error_d      = error_q;
    words_left_d = words_left_q;
    waddr_d      = waddr_q;
    pk_clear     = 1'b0;
    pk_beat      = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d  = ST_COUNT;
          halt_d   = 1'b1;
          done_d   = 1'b0;
          error_d  = 1'b0;
          pk_clear = 1'b1;
        end
      end
      ST_COUNT: begin
        if (xfer) begin
          if (bus.rx_data == 8'd0 || {1'b0, bus.rx_data} > MAX_N) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            state_d      = ST_DATA;
            words_left_d = bus.rx_data[ADDR_WIDTH:0];
            waddr_d      = '0;
            pk_clear     = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          pk_beat = 1'b1;
          if (pk_complete) begin
            mem_we_d     = 1'b1;
            mem_wdata_d  = pk_word;
            mem_addr_d   = waddr_q;
            waddr_d      = waddr_q + 1'b1;
            words_left_d = words_left_q - ONE_WORD;
            if (words_left_q == ONE_WORD) begin
              state_d = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          if (bus.rx_data == pk_acc) begin
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        halt_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d  = (state_d == ST_COUNT) || (state_d == ST_DATA) || (state_d == ST_CHECK);
    busy_d      = rx_ready_d || (state_d == ST_RELEASE);
    cpu_reset_d = (state_d == ST_RELEASE);
  end

  // Loader registers; reset also drops a write whose last byte lands on the reset edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      halt_q       <= 1'b0;
      cpu_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      words_left_q <= '0;
      waddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      halt_q       <= halt_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      words_left_q <= words_left_d;
      waddr_q      <= waddr_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, count limits, stalls, reset.
module tb_imem_loader;
  localparam int unsigned AW = 5;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic halt_cpu, cpu_reset, busy, done, error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .halt_cpu  (halt_cpu),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  int            wr_n = 0;
  int            pulses = 0;
  int            pulses_halted = 0;
  int            we_streak = 0;
  int            we_long = 0;
  logic [AW-1:0] wr_addr [0:255];
  logic [31:0]   wr_data [0:255];

  logic [7:0] frame [0:255];
  int         flen;

  // Record memory writes and cpu_reset pulses away from the active edge.
  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr[wr_n] = bus.mem_addr;
      wr_data[wr_n] = bus.mem_wdata;
      wr_n++;
      we_streak++;
      if (we_streak > 1) we_long++;
    end else begin
      we_streak = 0;
    end
    if (cpu_reset === 1'b1) begin
      pulses++;
      if (halt_cpu === 1'b1) pulses_halted++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Present one byte from a negedge and hold it until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    waited = 0;
    while (bus.rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 50) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout byte=%02h rx_ready=%b want 1", b, bus.rx_ready);
      bus.rx_valid = 1'b0;
    end else begin
      @(negedge clock);
      bus.rx_valid = 1'b0;
    end
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < flen; i++) send_byte(frame[i], gap);
  endtask

  task automatic set_good_frame(input logic [7:0] cks);
    frame[0] = 8'h02;
    frame[1] = 8'h12; frame[2] = 8'h34; frame[3] = 8'h56; frame[4] = 8'h78;
    frame[5] = 8'h9A; frame[6] = 8'hBC; frame[7] = 8'hDE; frame[8] = 8'hF0;
    frame[9] = cks;
    flen = 10;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'hAA;
    repeat (3) @(negedge clock);
    total++;
    if ({halt_cpu, cpu_reset, busy, done, error, bus.mem_we, bus.rx_ready} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want 0000000",
               {halt_cpu, cpu_reset, busy, done, error, bus.mem_we, bus.rx_ready});
    end
    total++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus addr=%h data=%h want 0/0", bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b0;
    repeat (4) @(negedge clock);
    total++;
    if (bus.rx_ready !== 1'b0 || busy !== 1'b0 || wr_n !== 0) begin
      bad++;
      $display("FAIL idle_no_transfer rx_ready=%b busy=%b writes=%0d want 0 0 0",
               bus.rx_ready, busy, wr_n);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_good_load(input int gap, input string tag);
    int b_wr, b_p, b_ph;
    b_wr = wr_n; b_p = pulses; b_ph = pulses_halted;
    set_good_frame(8'h00);
    pulse_start();
    total++;
    if (halt_cpu !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL %s_after_start halt=%b busy=%b done=%b err=%b want 1 1 0 0",
               tag, halt_cpu, busy, done, error);
    end
    send_frame(gap);
    repeat (3) @(negedge clock);
    total++;
    if (wr_n - b_wr !== 2) begin
      bad++;
      $display("FAIL %s_write_count got=%0d want 2", tag, wr_n - b_wr);
    end else begin
      total++;
      if (wr_addr[b_wr] !== 5'd0 || wr_data[b_wr] !== 32'h12345678) begin
        bad++;
        $display("FAIL %s_write0 got=%0d:%h want 0:12345678", tag, wr_addr[b_wr], wr_data[b_wr]);
      end
      total++;
      if (wr_addr[b_wr+1] !== 5'd1 || wr_data[b_wr+1] !== 32'h9ABCDEF0) begin
        bad++;
        $display("FAIL %s_write1 got=%0d:%h want 1:9abcdef0", tag, wr_addr[b_wr+1], wr_data[b_wr+1]);
      end
    end
    total++;
    if (pulses - b_p !== 1 || pulses_halted - b_ph !== 1) begin
      bad++;
      $display("FAIL %s_cpu_reset pulses=%0d halted=%0d want 1 1", tag, pulses - b_p, pulses_halted - b_ph);
    end
    total++;
    if (halt_cpu !== 1'b0 || done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_final halt=%b done=%b err=%b busy=%b want 0 1 0 0",
               tag, halt_cpu, done, error, busy);
    end
  endtask

  task automatic test_bad_checksum();
    int b_wr, b_p;
    b_wr = wr_n; b_p = pulses;
    set_good_frame(8'h01);
    pulse_start();
    send_frame(0);
    repeat (3) @(negedge clock);
    total++;
    if (wr_n - b_wr !== 2 || wr_data[b_wr] !== 32'h12345678 || wr_data[b_wr+1] !== 32'h9ABCDEF0) begin
      bad++;
      $display("FAIL badck_writes count=%0d d0=%h d1=%h want 2 12345678 9abcdef0",
               wr_n - b_wr, wr_data[b_wr], wr_data[b_wr+1]);
    end
    total++;
    if (pulses - b_p !== 0) begin
      bad++;
      $display("FAIL badck_cpu_reset got=%0d want 0", pulses - b_p);
    end
    total++;
    if (error !== 1'b1 || halt_cpu !== 1'b1 || bus.rx_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL badck_status err=%b halt=%b rdy=%b done=%b busy=%b want 1 1 0 0 0",
               error, halt_cpu, bus.rx_ready, done, busy);
    end
    test_good_load(0, "recover");
  endtask

  task automatic test_bad_count(input logic [7:0] n);
    int b_wr;
    b_wr = wr_n;
    pulse_start();
    send_byte(n, 0);
    repeat (3) @(negedge clock);
    total++;
    if (error !== 1'b1 || halt_cpu !== 1'b1 || bus.rx_ready !== 1'b0 || wr_n - b_wr !== 0) begin
      bad++;
      $display("FAIL badcount_%02h err=%b halt=%b rdy=%b writes=%0d want 1 1 0 0",
               n, error, halt_cpu, bus.rx_ready, wr_n - b_wr);
    end
  endtask

  task automatic test_max_count();
    int b_wr;
    int errs;
    logic [7:0] bb;
    b_wr = wr_n;
    frame[0] = 8'h20;
    for (int i = 0; i < 128; i++) begin
      bb = 8'(i);
      frame[1+i] = bb;
    end
    frame[129] = 8'h00;
    flen = 130;
    pulse_start();
    send_frame(0);
    repeat (3) @(negedge clock);
    total++;
    if (wr_n - b_wr !== 32 || done !== 1'b1) begin
      bad++;
      $display("FAIL maxcount_status writes=%0d done=%b want 32 1", wr_n - b_wr, done);
    end else begin
      errs = 0;
      for (int i = 0; i < 32; i++) begin
        if (wr_addr[b_wr+i] !== 5'(i) ||
            wr_data[b_wr+i] !== {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}) errs++;
      end
      total++;
      if (errs !== 0) begin
        bad++;
        $display("FAIL maxcount_words wrong=%0d want 0 (last got %0d:%h)", errs,
                 wr_addr[b_wr+31], wr_data[b_wr+31]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int b_wr, b_p;
    b_wr = wr_n; b_p = pulses;
    set_good_frame(8'h00);
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (wr_n - b_wr !== 1 || wr_addr[b_wr] !== 5'd0 || wr_data[b_wr] !== 32'h12345678) begin
      bad++;
      $display("FAIL midreset_writes count=%0d a0=%0d d0=%h want 1 0 12345678",
               wr_n - b_wr, wr_addr[b_wr], wr_data[b_wr]);
    end
    total++;
    if (halt_cpu !== 1'b0 || busy !== 1'b0 || bus.rx_ready !== 1'b0 || pulses - b_p !== 0) begin
      bad++;
      $display("FAIL midreset_state halt=%b busy=%b rdy=%b pulses=%0d want 0 0 0 0",
               halt_cpu, busy, bus.rx_ready, pulses - b_p);
    end

    // Reset on the same edge as the fourth byte of a word: that write must not happen.
    b_wr = wr_n;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(frame[i], 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = frame[4];
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (wr_n - b_wr !== 0 || halt_cpu !== 1'b0) begin
      bad++;
      $display("FAIL reset_edge_write writes=%0d halt=%b want 0 0", wr_n - b_wr, halt_cpu);
    end

    // Reload with a stray start in the middle of the data phase.
    b_wr = wr_n; b_p = pulses;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(frame[i], 0);
    pulse_start();
    for (int i = 4; i < flen; i++) send_byte(frame[i], 0);
    repeat (3) @(negedge clock);
    total++;
    if (wr_n - b_wr !== 2 || wr_data[b_wr+1] !== 32'h9ABCDEF0 || done !== 1'b1 ||
        error !== 1'b0 || pulses - b_p !== 1) begin
      bad++;
      $display("FAIL busy_start writes=%0d d1=%h done=%b err=%b pulses=%0d want 2 9abcdef0 1 0 1",
               wr_n - b_wr, wr_data[b_wr+1], done, error, pulses - b_p);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_good_load(0, "good");
    test_bad_checksum();
    test_bad_count(8'h00);
    test_bad_count(8'h21);
    test_max_count();
    test_good_load(1, "backpressure");
    test_reset_mid_load();
    total++;
    if (we_long !== 0) begin
      bad++;
      $display("FAIL mem_we_width long_pulses=%0d want 0", we_long);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
